// File: rtl/issue_stage_pkg.sv
// Shared CPU definitions (package cpuDefine): register numbers, data words,
// the opaque issue micro-op and the per-register mask type.
package cpuDefine;

   localparam int rfNum       = 32;
   localparam int GR_W        = 5;
   localparam int DATA_W      = 32;
   localparam int ISSUE_UOP_W = 64;

   typedef logic [GR_W-1:0]        Gr;
   typedef logic [DATA_W-1:0]      DType;
   typedef logic [ISSUE_UOP_W-1:0] IssueUop;
   typedef logic [rfNum-1:0]       GrMask;

endpackage

// File: rtl/issue_stage_scoreboard.sv
// Per-register busy scoreboard: one pending-writeback bit per general register.
// A writeback in the current cycle already counts as ready, and a new writer
// claiming the same register in that cycle keeps the bit set.
module reg_scoreboard
   import cpuDefine::*;
#(
   parameter int RF_NUM = rfNum
) (
   input  logic aclk,
   input  logic aresetn,
   input  logic flush,
   input  logic set_en,
   input  Gr    set_addr,
   input  logic wb_en,
   input  Gr    wb_addr,
   input  Gr    rj_addr,
   input  Gr    rk_addr,
   input  Gr    rd_addr,
   input  Gr    dst_addr,
   output logic rj_busy,
   output logic rk_busy,
   output logic rd_busy,
   output logic dst_busy
);

   logic [RF_NUM-1:0] busy;
   logic [RF_NUM-1:0] clr_mask;
   logic [RF_NUM-1:0] set_mask;
   logic [RF_NUM-1:0] eff_busy;
   logic [RF_NUM-1:0] busy_next;

   // Build set/clear masks; r0 is never tracked, and set overrides clear
   always_comb begin
      clr_mask = '0;
      set_mask = '0;
      if (wb_en && (wb_addr != '0)) begin
         clr_mask[wb_addr] = 1'b1;
      end
      if (set_en && (set_addr != '0)) begin
         set_mask[set_addr] = 1'b1;
      end
      eff_busy     = busy & ~clr_mask;
      busy_next    = eff_busy | set_mask;
      busy_next[0] = 1'b0;
   end

   assign rj_busy  = eff_busy[rj_addr];
   assign rk_busy  = eff_busy[rk_addr];
   assign rd_busy  = eff_busy[rd_addr];
   assign dst_busy = eff_busy[dst_addr];

   // Busy vector: a flush wipes every pending writer at once
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         busy <= '0;
      end else if (flush) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

endmodule

// File: rtl/issue_stage.sv
// Single-entry issue stage: reads operands from the regfile, holds each
// instruction back while any operand or its destination awaits writeback,
// and registers the issued instruction toward execute.
module issue_stage
   import cpuDefine::*;
#(
   parameter int UOP_W  = ISSUE_UOP_W,
   parameter int RF_NUM = rfNum
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             flush,
   input  logic             id_valid,
   output logic             id_ready,
   input  Gr                id_rj,
   input  Gr                id_rk,
   input  Gr                id_rd,
   input  logic             id_use_rj,
   input  logic             id_use_rk,
   input  logic             id_use_rd,
   input  logic             id_wr_en,
   input  logic [UOP_W-1:0] id_uop,
   output Gr                rf_rj_addr,
   output Gr                rf_rk_addr,
   output Gr                rf_rd_addr,
   input  DType             rf_rj_data,
   input  DType             rf_rk_data,
   input  DType             rf_rd_data,
   input  logic             wb_en,
   input  Gr                wb_addr,
   output logic             ex_valid,
   input  logic             ex_ready,
   output DType             ex_rj,
   output DType             ex_rk,
   output DType             ex_rd,
   output logic             ex_wr_en,
   output Gr                ex_wr_dst,
   output logic [UOP_W-1:0] ex_uop,
   output logic [31:0]      stall_cnt
);

   logic rj_busy;
   logic rk_busy;
   logic rd_busy;
   logic dst_busy;
   logic hazard;
   logic fire;

   assign rf_rj_addr = id_rj;
   assign rf_rk_addr = id_rk;
   assign rf_rd_addr = id_rd;

   reg_scoreboard #(
      .RF_NUM (RF_NUM)
   ) u_sb (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .flush    (flush),
      .set_en   (fire && id_wr_en),
      .set_addr (id_rd),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .rj_addr  (id_rj),
      .rk_addr  (id_rk),
      .rd_addr  (id_rd),
      .dst_addr (id_rd),
      .rj_busy  (rj_busy),
      .rk_busy  (rk_busy),
      .rd_busy  (rd_busy),
      .dst_busy (dst_busy)
   );

   // The last term is the WAW stall that lets one busy bit per register suffice
   assign hazard   = (id_use_rj && rj_busy) || (id_use_rk && rk_busy) ||
                     (id_use_rd && rd_busy) || (id_wr_en && dst_busy);
   assign id_ready = !hazard && (!ex_valid || ex_ready) && !flush;
   assign fire     = id_valid && id_ready;

   // Output pipeline register toward execute; flush kills the entry
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         ex_valid  <= 1'b0;
         ex_rj     <= '0;
         ex_rk     <= '0;
         ex_rd     <= '0;
         ex_wr_en  <= 1'b0;
         ex_wr_dst <= '0;
         ex_uop    <= '0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (fire) begin
         ex_valid  <= 1'b1;
         ex_rj     <= rf_rj_data;
         ex_rk     <= rf_rk_data;
         ex_rd     <= rf_rd_data;
         ex_wr_en  <= id_wr_en;
         ex_wr_dst <= id_rd;
         ex_uop    <= id_uop;
      end else if (ex_ready) begin
         ex_valid <= 1'b0;
      end
   end

   // Saturating count of cycles an offered instruction waits on a hazard
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         stall_cnt <= '0;
      end else if (id_valid && hazard && !flush && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_issue_stage.sv
// Directed bench for issue_stage: a regfile model with writeback bypass, and a
// monitor that pops expected execute-side transfers from a queue.
module tb_issue_stage;
   import cpuDefine::*;

   typedef struct {
      DType    rj;
      DType    rk;
      DType    rd;
      logic    wr_en;
      Gr       dst;
      IssueUop uop;
   } exp_t;

   logic        aclk;
   logic        aresetn;
   logic        flush;
   logic        id_valid;
   logic        id_ready;
   Gr           id_rj, id_rk, id_rd;
   logic        id_use_rj, id_use_rk, id_use_rd;
   logic        id_wr_en;
   IssueUop     id_uop;
   Gr           rf_rj_addr, rf_rk_addr, rf_rd_addr;
   DType        rf_rj_data, rf_rk_data, rf_rd_data;
   logic        wb_en;
   Gr           wb_addr;
   DType        wb_data;
   logic        ex_valid;
   logic        ex_ready;
   DType        ex_rj, ex_rk, ex_rd;
   logic        ex_wr_en;
   Gr           ex_wr_dst;
   IssueUop     ex_uop;
   logic [31:0] stall_cnt;

   DType rf_mem [0:31];
   exp_t exp_q [$];
   int   checks = 0;
   int   errors = 0;

   issue_stage u_dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .flush      (flush),
      .id_valid   (id_valid),
      .id_ready   (id_ready),
      .id_rj      (id_rj),
      .id_rk      (id_rk),
      .id_rd      (id_rd),
      .id_use_rj  (id_use_rj),
      .id_use_rk  (id_use_rk),
      .id_use_rd  (id_use_rd),
      .id_wr_en   (id_wr_en),
      .id_uop     (id_uop),
      .rf_rj_addr (rf_rj_addr),
      .rf_rk_addr (rf_rk_addr),
      .rf_rd_addr (rf_rd_addr),
      .rf_rj_data (rf_rj_data),
      .rf_rk_data (rf_rk_data),
      .rf_rd_data (rf_rd_data),
      .wb_en      (wb_en),
      .wb_addr    (wb_addr),
      .ex_valid   (ex_valid),
      .ex_ready   (ex_ready),
      .ex_rj      (ex_rj),
      .ex_rk      (ex_rk),
      .ex_rd      (ex_rd),
      .ex_wr_en   (ex_wr_en),
      .ex_wr_dst  (ex_wr_dst),
      .ex_uop     (ex_uop),
      .stall_cnt  (stall_cnt)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Regfile model: combinational read with same-cycle writeback bypass
   always_comb begin
      rf_rj_data = (wb_en && wb_addr == rf_rj_addr && rf_rj_addr != '0) ? wb_data : rf_mem[rf_rj_addr];
      rf_rk_data = (wb_en && wb_addr == rf_rk_addr && rf_rk_addr != '0) ? wb_data : rf_mem[rf_rk_addr];
      rf_rd_data = (wb_en && wb_addr == rf_rd_addr && rf_rd_addr != '0) ? wb_data : rf_mem[rf_rd_addr];
   end

   always @(posedge aclk) begin
      if (wb_en && wb_addr != '0) rf_mem[wb_addr] <= wb_data;
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input Gr rj, input Gr rk, input Gr rd,
                                input logic urj, input logic urk, input logic urd,
                                input logic wr, input IssueUop uop);
      id_valid  = v;
      id_rj     = rj;
      id_rk     = rk;
      id_rd     = rd;
      id_use_rj = urj;
      id_use_rk = urk;
      id_use_rd = urd;
      id_wr_en  = wr;
      id_uop    = uop;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
   endtask

   task automatic pushExp(input DType rj, input DType rk, input DType rd,
                          input logic wr, input Gr dst, input IssueUop uop);
      exp_t e;
      e.rj = rj; e.rk = rk; e.rd = rd; e.wr_en = wr; e.dst = dst; e.uop = uop;
      exp_q.push_back(e);
   endtask

   // Advance to just after the next rising edge, then inputs may change
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   // Monitor: every accepted execute-side transfer must match the queue head
   always @(negedge aclk) begin
      exp_t e;
      if (aresetn && ex_valid && ex_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_ex: got uop %h expected no transfer", ex_uop);
         end else begin
            e = exp_q.pop_front();
            checkOutput("ex_rj", 64'(ex_rj), 64'(e.rj));
            checkOutput("ex_rk", 64'(ex_rk), 64'(e.rk));
            checkOutput("ex_rd", 64'(ex_rd), 64'(e.rd));
            checkOutput("ex_wr_en", 64'(ex_wr_en), 64'(e.wr_en));
            checkOutput("ex_wr_dst", 64'(ex_wr_dst), 64'(e.dst));
            checkOutput("ex_uop", ex_uop, e.uop);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 32; i++) rf_mem[i] = 32'h100 + i;
      rf_mem[0] = 32'd0;
      rf_mem[2] = 32'd5;
      rf_mem[3] = 32'd7;
      aresetn  = 1'b0;
      flush    = 1'b0;
      wb_en    = 1'b0;
      wb_addr  = '0;
      wb_data  = '0;
      ex_ready = 1'b1;
      idle();

      // Reset state
      #3;
      checkOutput("rst_id_ready", 64'(id_ready), 64'd1);
      checkOutput("rst_ex_valid", 64'(ex_valid), 64'd0);
      checkOutput("rst_stall_cnt", 64'(stall_cnt), 64'd0);
      checkOutput("rst_ex_uop", ex_uop, 64'd0);
      #9 aresetn = 1'b1;

      // r1 = r2 + r3
      tick();
      applyStimulus(1'b1, 5'd2, 5'd3, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 64'hA1);
      pushExp(32'd5, 32'd7, 32'h101, 1'b1, 5'd1, 64'hA1);
      settle();
      checkOutput("t1_id_ready", 64'(id_ready), 64'd1);
      tick();
      idle();
      settle();
      checkOutput("t1_ex_valid", 64'(ex_valid), 64'd1);
      checkOutput("t1_busy1", 64'(u_dut.u_sb.busy[1]), 64'd1);

      // RAW: writer to r4, then a stalled reader released by writeback
      tick();
      applyStimulus(1'b1, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 64'hB1);
      pushExp(32'd0, 32'd0, 32'h104, 1'b1, 5'd4, 64'hB1);
      tick();
      applyStimulus(1'b1, 5'd4, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 64'hB2);
      pushExp(32'h1234, 32'd0, 32'h107, 1'b0, 5'd7, 64'hB2);
      settle();
      checkOutput("raw_id_ready_c1", 64'(id_ready), 64'd0);
      tick();
      settle();
      checkOutput("raw_id_ready_c2", 64'(id_ready), 64'd0);
      checkOutput("raw_stall_c2", 64'(stall_cnt), 64'd1);
      tick();
      wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h1234;
      settle();
      checkOutput("raw_stall_c3", 64'(stall_cnt), 64'd2);
      checkOutput("raw_id_ready_wb", 64'(id_ready), 64'd1);
      tick();
      wb_en = 1'b0;
      idle();
      settle();
      checkOutput("raw_ex_valid", 64'(ex_valid), 64'd1);
      checkOutput("raw_busy4", 64'(u_dut.u_sb.busy[4]), 64'd0);
      checkOutput("raw_stall_after", 64'(stall_cnt), 64'd2);

      // WAW on r5
      tick();
      applyStimulus(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 64'hC1);
      pushExp(32'd0, 32'd0, 32'h105, 1'b1, 5'd5, 64'hC1);
      tick();
      applyStimulus(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 64'hC2);
      pushExp(32'd5, 32'd0, 32'h55, 1'b1, 5'd5, 64'hC2);
      settle();
      checkOutput("waw_id_ready", 64'(id_ready), 64'd0);
      tick();
      wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h55;
      settle();
      checkOutput("waw_id_ready_wb", 64'(id_ready), 64'd1);
      tick();
      wb_en = 1'b0;
      idle();
      settle();
      checkOutput("waw_busy5", 64'(u_dut.u_sb.busy[5]), 64'd1);
      checkOutput("waw_stall", 64'(stall_cnt), 64'd3);

      // Backpressure, then back-to-back issue
      tick();
      applyStimulus(1'b1, 5'd2, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 64'hD1);
      pushExp(32'd5, 32'd7, 32'd0, 1'b0, 5'd0, 64'hD1);
      settle();
      checkOutput("bp_id_ready_first", 64'(id_ready), 64'd1);
      tick();
      ex_ready = 1'b0;
      applyStimulus(1'b1, 5'd3, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 64'hD2);
      pushExp(32'd7, 32'd5, 32'd0, 1'b0, 5'd0, 64'hD2);
      for (int c = 0; c < 3; c++) begin
         settle();
         checkOutput("bp_ex_valid", 64'(ex_valid), 64'd1);
         checkOutput("bp_ex_rj", 64'(ex_rj), 64'd5);
         checkOutput("bp_ex_rk", 64'(ex_rk), 64'd7);
         checkOutput("bp_ex_uop", ex_uop, 64'hD1);
         checkOutput("bp_id_ready", 64'(id_ready), 64'd0);
         tick();
      end
      ex_ready = 1'b1;
      settle();
      checkOutput("bp_id_ready_release", 64'(id_ready), 64'd1);
      checkOutput("bp_stall", 64'(stall_cnt), 64'd3);
      tick();
      applyStimulus(1'b1, 5'd6, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'hD3);
      pushExp(32'h106, 32'd0, 32'd0, 1'b0, 5'd0, 64'hD3);
      settle();
      checkOutput("b2b_id_ready", 64'(id_ready), 64'd1);

      // r0 writes are not tracked and r0 reads never stall
      tick();
      applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 64'hE1);
      pushExp(32'd0, 32'd0, 32'd0, 1'b1, 5'd0, 64'hE1);
      tick();
      applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 64'hE2);
      pushExp(32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 64'hE2);
      settle();
      checkOutput("r0_id_ready", 64'(id_ready), 64'd1);
      checkOutput("r0_busy0", 64'(u_dut.u_sb.busy[0]), 64'd0);
      tick();
      idle();
      settle();
      checkOutput("r0_stall", 64'(stall_cnt), 64'd3);

      // Flush with r6/r9 pending and an entry held in execute
      tick();
      applyStimulus(1'b1, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 64'hF1);
      pushExp(32'd0, 32'd0, 32'h106, 1'b1, 5'd6, 64'hF1);
      tick();
      applyStimulus(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 64'hF2);
      tick();
      ex_ready = 1'b0;
      idle();
      settle();
      checkOutput("fl_busy6", 64'(u_dut.u_sb.busy[6]), 64'd1);
      checkOutput("fl_busy9", 64'(u_dut.u_sb.busy[9]), 64'd1);
      checkOutput("fl_ex_valid_pre", 64'(ex_valid), 64'd1);
      tick();
      flush = 1'b1;
      applyStimulus(1'b1, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h61);
      settle();
      checkOutput("fl_id_ready", 64'(id_ready), 64'd0);
      tick();
      flush = 1'b0;
      ex_ready = 1'b1;
      idle();
      settle();
      checkOutput("fl_ex_valid", 64'(ex_valid), 64'd0);
      checkOutput("fl_busy_all", 64'(u_dut.u_sb.busy), 64'd0);
      checkOutput("fl_stall", 64'(stall_cnt), 64'd3);

      // Reset asserted while a reader is stalled
      tick();
      applyStimulus(1'b1, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 64'h71);
      pushExp(32'd0, 32'd0, 32'h108, 1'b1, 5'd8, 64'h71);
      tick();
      applyStimulus(1'b1, 5'd8, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h72);
      tick();
      settle();
      checkOutput("rs_id_ready_stall", 64'(id_ready), 64'd0);
      checkOutput("rs_stall_pre", 64'(stall_cnt), 64'd4);
      aresetn = 1'b0;
      #1;
      checkOutput("rs_ex_valid", 64'(ex_valid), 64'd0);
      checkOutput("rs_ex_uop", ex_uop, 64'd0);
      checkOutput("rs_ex_wr_dst", 64'(ex_wr_dst), 64'd0);
      checkOutput("rs_ex_rd", 64'(ex_rd), 64'd0);
      checkOutput("rs_stall_cnt", 64'(stall_cnt), 64'd0);
      checkOutput("rs_busy_all", 64'(u_dut.u_sb.busy), 64'd0);
      checkOutput("rs_id_ready", 64'(id_ready), 64'd1);
      idle();
      aresetn = 1'b1;

      tick();
      tick();
      checkOutput("exp_q_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/issue_stage.md
Name: issue_stage

Overview:
Single-entry issue stage between decode and execute, directly upstream of the general register file.
- Drives the regfile read addresses and captures the returned operands into an output pipeline register.
- Keeps a per-register busy scoreboard so no instruction issues while a source or destination is still pending writeback.
- Uses valid/ready handshakes on both sides and supports a commit-point flush.

Parameters:
UOP_W, 64, width of the opaque decoded micro-op bundle passed through to execute
RF_NUM, rfNum (32), number of general registers tracked by the scoreboard

Ports:
aclk  input  1  clock, all state on posedge
aresetn  input  1  asynchronous active-low reset
flush  input  1  kill output entry and clear scoreboard
id_valid  input  1  decode offers an instruction
id_ready  output  1  issue accepts this cycle
id_rj / id_rk / id_rd  input  Gr  source/dest register numbers
id_use_rj / id_use_rk / id_use_rd  input  1  operand is actually read (rd is read by stores/branches)
id_wr_en  input  1  instruction writes a GR
id_uop  input  UOP_W  opaque micro-op
rf_rj_addr / rf_rk_addr / rf_rd_addr  output  Gr  regfile read addresses, combinational from id_*
rf_rj_data / rf_rk_data / rf_rd_data  input  DType  regfile read data, already wb-bypassed
wb_en  input  1  writeback strobe, the same signal that drives the regfile write port
wb_addr  input  Gr  writeback register
ex_valid  output  1  entry valid toward execute
ex_ready  input  1  execute accepts
ex_rj / ex_rk / ex_rd  output  DType  captured operands
ex_wr_en  output  1  registered id_wr_en
ex_wr_dst  output  Gr  registered id_rd
ex_uop  output  UOP_W  registered id_uop
stall_cnt  output  32  hazard stall cycles, saturating

Behaviour:
- Reset (async, aresetn=0): ex_valid=0, ex_rj/ex_rk/ex_rd=0, ex_wr_en=0, ex_wr_dst=0, ex_uop=0, busy[*]=0, stall_cnt=0. id_ready depends only on these, so it is 1 during reset. A reset mid-stall drops everything in flight.
- rf_*_addr = id_* at all times. The regfile is combinational with same-cycle wb bypass, so operand data is valid in the same cycle.
- clr_mask: the one-hot of wb_addr when wb_en=1 and wb_addr!=0, otherwise 0. eff_busy = busy & ~clr_mask, so a register written back this cycle counts as ready.
- Hazard: (id_use_rj & eff_busy[id_rj]) | (id_use_rk & eff_busy[id_rk]) | (id_use_rd & eff_busy[id_rd]) | (id_wr_en & eff_busy[id_rd]). The last term is the WAW stall, which lets one busy bit per register suffice.
- id_ready = !hazard && (!ex_valid || ex_ready) && !flush.
- fire = id_valid && id_ready. On fire, the output register loads the operands, uop, wr_en and dst; ex_valid=1. Latency is one cycle from id to ex.
- If ex_valid && !ex_ready and no flush: all ex_* hold stable.
- If ex_valid && ex_ready and no fire: ex_valid=0 next cycle. Data regs may hold stale values.
- Scoreboard next state: busy_next = (busy & ~clr_mask) | set_mask, where set_mask = one-hot of id_rd if fire && id_wr_en && id_rd!=0. When set and clear hit the same register in one cycle, set wins. busy[0] is always 0.
- A wb to a non-busy register is legal and leaves busy unchanged.
- flush (highest priority):
  - next cycle ex_valid=0 and busy[*]=0;
  - no fire occurs that cycle;
  - stall_cnt is unaffected.
  - Upstream guarantees flush is asserted only when no older writer remains in flight.
- stall_cnt increments on cycles with id_valid && hazard && !flush. It saturates at 32'hFFFF_FFFF.
- Reading r0 never hazards; an operand with use=0 never hazards.

Decomposition:
- Package cpuDefine already holds Gr, DType and rfNum. Add IssueUop (logic [UOP_W-1:0]) and a GrMask typedef (logic [rfNum-1:0]) there.
- Sub-module reg_scoreboard holds the busy vector and computes set/clr and eff_busy.
  - Inputs: aclk, aresetn, flush, set_en, set_addr, wb_en, wb_addr, query addresses.
  - Outputs: three source busy flags plus dest busy.
- issue_stage holds the handshake, the output register and stall_cnt.

Test Plan:
- Reset then id r1=r2+r3 (rf r2=5, r3=7): ex_valid=1 the next cycle, ex_rj=5, ex_rk=7, ex_wr_dst=1, busy[1]=1.
- Issue a write to r4, then a reader of r4 with no wb: id_ready=0 and stall_cnt increments each cycle. Pulse wb_en/wb_addr=4 with data 0x1234: the reader fires that same cycle with ex_rj=0x1234 the next cycle, and busy[4]=0 after the wb pulse.
- WAW: r5 busy, new writer to r5 stalls; on wb to r5 the new writer fires in the same cycle and busy[5] remains 1.
- Backpressure: ex_ready=0 for 3 cycles with ex_valid=1, so ex_* are unchanged and id_ready=0. Then ex_ready=1 with id_valid: back-to-back fire.
- Writes and hazards on r0: a write to r0 leaves busy[0]=0, and a following reader of r0 fires with no stall, operand 0.
- Flush with ex_valid=1 and busy={r6,r9}: next cycle ex_valid=0, busy=0, and id_valid in the flush cycle is not accepted. Separately, reset asserted mid-stall clears all outputs asynchronously.
